// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - switch game phase FSM, LFSR target, 1 Hz countdown, debounce and scoring
// Optional feature macro: SCORE_MULT_EN (award doubles after every 5 rounds passed).
module game_round_controller #(
    parameter int TICK_DIV  = 50000000,
    parameter int ROUND_SEC = 15,
    parameter int BREAK_SEC = 5,
    parameter int DEBOUNCE  = 1000000
) (
    input  logic       clk,
    input  logic       reset_btn,
    input  logic       start,
    input  logic [9:0] sw,
    output logic [9:0] led_target,
    output logic [5:0] time_left,
    output logic [9:0] score,
    output logic [6:0] round_num,
    output logic [2:0] phase,
    output logic       game_over
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PROMPT = 3'd1,
        ROUND  = 3'd2,
        BREAK  = 3'd3,
        OVER   = 3'd4
    } phase_t;

    phase_t        state_q, state_d;
    logic [9:0]    lfsr_q;
    logic [9:0]    target_q, target_d;
    logic [9:0]    score_q, score_d;
    logic [5:0]    time_q, time_d;
    logic [6:0]    round_q, round_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          start_q;
    logic          over_q, over_d;

    logic          start_rise;
    logic          tick;
    logic          match;
    logic          pass;
    logic [31:0]   award;
    logic [32:0]   score_sum;

    assign start_rise = start & ~start_q;
    assign tick       = ((state_q == ROUND) || (state_q == BREAK)) && (tick_cnt_q == TW'(TICK_DIV - 1));
    assign match      = (sw == target_q);
    assign pass       = match && (deb_q == DW'(DEBOUNCE));

`ifdef SCORE_MULT_EN
    assign award = 32'd2 << (round_q / 7'd5);
`else
    assign award = 32'd2;
`endif
    // Wide sum so a large shifted award still saturates instead of wrapping.
    assign score_sum = {23'd0, score_q} + {1'b0, award};

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        time_d     = time_q;
        score_d    = score_q;
        round_d    = round_q;
        tick_cnt_d = '0;
        deb_d      = '0;
        over_d     = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                over_d = (state_q == OVER);
                if (start_rise) begin
                    score_d = 10'd0;
                    round_d = 7'd0;
                    over_d  = 1'b0;
                    state_d = PROMPT;
                end
            end
            PROMPT: begin
                target_d = lfsr_q;
                if (lfsr_q != sw) begin
                    state_d = ROUND;
                    time_d  = 6'(ROUND_SEC);
                end
            end
            ROUND: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                deb_d      = match ? deb_q + DW'(1) : '0;
                // A pass outranks a timeout landing on the same cycle.
                if (pass) begin
                    round_d    = (round_q == 7'd127) ? round_q : round_q + 7'd1;
                    score_d    = (score_sum > 33'd1023) ? 10'd1023 : score_sum[9:0];
                    state_d    = BREAK;
                    time_d     = 6'(BREAK_SEC);
                    target_d   = 10'd0;
                    tick_cnt_d = '0;
                    deb_d      = '0;
                end else if (tick) begin
                    if (time_q == 6'd1) begin
                        time_d   = 6'd0;
                        state_d  = OVER;
                        over_d   = 1'b1;
                        target_d = 10'd0;
                    end else begin
                        time_d = time_q - 6'd1;
                    end
                end
            end
            BREAK: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (tick) begin
                    if (time_q == 6'd1) begin
                        time_d  = 6'd0;
                        state_d = PROMPT;
                    end else begin
                        time_d = time_q - 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            state_q    <= IDLE;
            lfsr_q     <= 10'h2A5;
            target_q   <= 10'd0;
            score_q    <= 10'd0;
            time_q     <= 6'd0;
            round_q    <= 7'd0;
            tick_cnt_q <= '0;
            deb_q      <= '0;
            start_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
            target_q   <= target_d;
            score_q    <= score_d;
            time_q     <= time_d;
            round_q    <= round_d;
            tick_cnt_q <= tick_cnt_d;
            deb_q      <= deb_d;
            start_q    <= start;
            over_q     <= over_d;
        end
    end

    assign led_target = target_q;
    assign time_left  = time_q;
    assign score      = score_q;
    assign round_num  = round_q;
    assign phase      = state_q;
    assign game_over  = over_q;
endmodule

// File: tb/tb_game_round_controller.sv
// tb/tb_game_round_controller.sv - self-checking bench for game_round_controller
module tb_game_round_controller;
    localparam int TICK_DIV  = 4;
    localparam int ROUND_SEC = 3;
    localparam int BREAK_SEC = 2;
    localparam int DEBOUNCE  = 2;
`ifdef SCORE_MULT_EN
    localparam int EXP_SCORE6   = 14;
    localparam int EXP_SCORE130 = 1023;
`else
    localparam int EXP_SCORE6   = 12;
    localparam int EXP_SCORE130 = 260;
`endif

    logic       clk;
    logic       reset_btn;
    logic       start;
    logic [9:0] sw;
    logic [9:0] led_target;
    logic [5:0] time_left;
    logic [9:0] score;
    logic [6:0] round_num;
    logic [2:0] phase;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    game_round_controller #(
        .TICK_DIV (TICK_DIV),
        .ROUND_SEC(ROUND_SEC),
        .BREAK_SEC(BREAK_SEC),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset_btn (reset_btn),
        .start     (start),
        .sw        (sw),
        .led_target(led_target),
        .time_left (time_left),
        .score     (score),
        .round_num (round_num),
        .phase     (phase),
        .game_over (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: game phase and counters as plain integers.
    int m_phase, m_target, m_time, m_score, m_round, m_lfsr, m_tick, m_run, m_start_prev;

    task automatic model_reset();
        m_phase = 0; m_target = 0; m_time = 0; m_score = 0; m_round = 0;
        m_lfsr = 'h2A5; m_tick = 0; m_run = 0; m_start_prev = 0;
    endtask

    task automatic model_step();
        int n_phase, n_target, n_time, n_score, n_round, n_tick, n_run;
        bit rise, tk, match;
        longint aw;
        n_phase = m_phase; n_target = m_target; n_time = m_time;
        n_score = m_score; n_round = m_round; n_tick = 0; n_run = 0;
        rise  = start && (m_start_prev == 0);
        tk    = (m_phase == 2 || m_phase == 3) && (m_tick == TICK_DIV - 1);
        match = (int'(sw) == m_target);
`ifdef SCORE_MULT_EN
        aw = 64'd2 << (m_round / 5);
`else
        aw = 2;
`endif
        case (m_phase)
            0, 4: if (rise) begin n_score = 0; n_round = 0; n_phase = 1; end
            1: begin
                n_target = m_lfsr;
                if (m_lfsr != int'(sw)) begin n_phase = 2; n_time = ROUND_SEC; end
            end
            2: begin
                n_tick = (m_tick + 1) % TICK_DIV;
                n_run  = match ? m_run + 1 : 0;
                if (match && m_run >= DEBOUNCE) begin
                    n_round  = (m_round >= 127) ? 127 : m_round + 1;
                    n_score  = (m_score + aw > 1023) ? 1023 : m_score + int'(aw);
                    n_phase  = 3; n_time = BREAK_SEC; n_target = 0; n_tick = 0; n_run = 0;
                end else if (tk) begin
                    if (m_time == 1) begin n_time = 0; n_phase = 4; n_target = 0; end
                    else n_time = m_time - 1;
                end
            end
            3: begin
                n_tick = (m_tick + 1) % TICK_DIV;
                if (tk) begin
                    if (m_time == 1) begin n_time = 0; n_phase = 1; end
                    else n_time = m_time - 1;
                end
            end
            default: n_phase = 0;
        endcase
        m_lfsr = ((m_lfsr << 1) & 'h3FF) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
        m_start_prev = int'(start);
        m_phase = n_phase; m_target = n_target; m_time = n_time;
        m_score = n_score; m_round = n_round; m_tick = n_tick; m_run = n_run;
    endtask

    always @(negedge clk) begin
        if (reset_btn) model_reset();
        check("m_phase", int'(phase), m_phase);
        check("m_led_target", int'(led_target), m_target);
        check("m_time_left", int'(time_left), m_time);
        check("m_score", int'(score), m_score);
        check("m_round_num", int'(round_num), m_round);
        check("m_game_over", int'(game_over), (m_phase == 4) ? 1 : 0);
        if (!reset_btn) model_step();
    end

    task automatic wait_phase(input int p, input int budget, input string nm);
        int n;
        n = 0;
        while (int'(phase) != p && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(phase) != p) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, phase %0d expected %0d", nm, phase, p);
        end
    endtask

    // Restart from IDLE/OVER with sw=0; returns at the first ROUND negedge.
    task automatic pulse_start(input string nm);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check({nm, "_prompt_phase"}, int'(phase), 1);
        check({nm, "_prompt_score"}, int'(score), 0);
        check({nm, "_prompt_round"}, int'(round_num), 0);
        @(negedge clk);
        check({nm, "_round_phase"}, int'(phase), 2);
        check({nm, "_round_time"}, int'(time_left), ROUND_SEC);
        check({nm, "_led_nonzero"}, (led_target != 10'd0) ? 1 : 0, 1);
    endtask

    // Called at the first ROUND negedge: match for 3 cycles, pass lands at the 4th edge.
    task automatic pass_round();
        @(posedge clk); #1 sw = led_target;
        repeat (3) @(posedge clk);
        #1 sw = 10'd0;
    endtask

    initial begin
        logic [9:0] tgt;
        reset_btn = 1'b1;
        start = 1'b0;
        sw = 10'd0;
        repeat (3) @(posedge clk);
        #1 reset_btn = 1'b0;
        @(negedge clk);
        check("reset_phase", int'(phase), 0);
        check("reset_score", int'(score), 0);
        check("reset_led", int'(led_target), 0);
        check("reset_time", int'(time_left), 0);

        // Countdown to timeout with sw held at 0.
        pulse_start("t1");
        repeat (4) @(negedge clk);
        check("t1_time2", int'(time_left), 2);
        repeat (4) @(negedge clk);
        check("t1_time1", int'(time_left), 1);
        repeat (4) @(negedge clk);
        check("t1_over_phase", int'(phase), 4);
        check("t1_game_over", int'(game_over), 1);
        check("t1_time0", int'(time_left), 0);
        check("t1_score", int'(score), 0);

        // Clean pass, then break returns to PROMPT after 8 cycles.
        pulse_start("t2");
        pass_round();
        @(negedge clk);
        check("t2_break_phase", int'(phase), 3);
        check("t2_round", int'(round_num), 1);
        check("t2_score", int'(score), 2);
        check("t2_time", int'(time_left), BREAK_SEC);
        repeat (8) @(negedge clk);
        check("t2_prompt_again", int'(phase), 1);
        @(negedge clk);
        check("t2_round_again", int'(phase), 2);

        // Glitching match never passes.
        tgt = led_target;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 sw = tgt;
            @(posedge clk); #1 sw = 10'd0;
        end
        wait_phase(4, 5, "t3_over");
        check("t3_round", int'(round_num), 1);
        check("t3_score", int'(score), 2);
        check("t3_game_over", int'(game_over), 1);

        // Pass completes on the same edge as the final tick.
        pulse_start("t4");
        repeat (9) @(posedge clk);
        #1 sw = led_target;
        repeat (3) @(posedge clk);
        #1 sw = 10'd0;
        @(negedge clk);
        check("t4_phase", int'(phase), 3);
        check("t4_round", int'(round_num), 1);
        check("t4_game_over", int'(game_over), 0);
        check("t4_time", int'(time_left), BREAK_SEC);

        // Six rounds of scoring.
        wait_phase(2, 40, "t5_round");
        wait_phase(4, 40, "t5_over");
        pulse_start("t5");
        for (int i = 0; i < 6; i++) begin
            pass_round();
            wait_phase(2, 40, "t5_next");
        end
        check("t5_score6", int'(score), EXP_SCORE6);
        check("t5_round6", int'(round_num), 6);

        // Asynchronous reset mid-round, then restart from OVER clears the score.
        wait_phase(4, 40, "t6_over");
        pulse_start("t6");
        for (int i = 0; i < 2; i++) begin
            pass_round();
            wait_phase(2, 40, "t6_next");
        end
        check("t6_score4", int'(score), 4);
        @(posedge clk); #2 reset_btn = 1'b1;
        #1;
        check("t6_rst_phase", int'(phase), 0);
        check("t6_rst_score", int'(score), 0);
        check("t6_rst_round", int'(round_num), 0);
        check("t6_rst_led", int'(led_target), 0);
        check("t6_rst_time", int'(time_left), 0);
        @(posedge clk); #1 reset_btn = 1'b0;
        pulse_start("t6b");
        pass_round();
        wait_phase(2, 40, "t6b_round");
        wait_phase(4, 40, "t6b_over");
        check("t6_over_hold_score", int'(score), 2);
        check("t6_over_hold_round", int'(round_num), 1);
        pulse_start("t6c");

        // Saturation of round_num (and score with the multiplier).
        for (int i = 0; i < 130; i++) begin
            pass_round();
            wait_phase(2, 40, "t7_next");
        end
        check("t7_round_sat", int'(round_num), 127);
        check("t7_score", int'(score), EXP_SCORE130);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/game_round_controller.md
# game_round_controller

Round sequencer for the switch game. Owns the game phase state machine, generates a pseudo-random target switch pattern for each round, and drives the countdown for round and break phases at 1 Hz. It checks the player's switches against the target and keeps the round count and the score. It sits between the board inputs (KEY/SW) and the LEDR and HEX display drivers.

## Interface
Parameters:
- TICK_DIV, 50000000: clk cycles per 1 s tick.
- ROUND_SEC, 15: countdown seconds loaded for a round.
- BREAK_SEC, 5: countdown seconds loaded for a break.
- DEBOUNCE, 1000000: consecutive clk cycles of switch match required to pass.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_btn  in  1  asynchronous, active-high reset.
- start  in  1  start/restart request, synchronous level; rising edge detected internally.
- sw  in  10  player switches.
- led_target  out  10  target pattern, shown on LEDR; 0 outside PROMPT/ROUND.
- time_left  out  6  seconds remaining in the current ROUND/BREAK; 0 elsewhere.
- score  out  10  accumulated score, saturating at 1023.
- round_num  out  7  rounds passed, saturating at 127.
- phase  out  3  IDLE=0, PROMPT=1, ROUND=2, BREAK=3, OVER=4.
- game_over  out  1  high while phase==OVER.

## Operation
- Reset values: phase IDLE, and all outputs 0. The LFSR is set to 10'h2A5, the tick counter to 0, and the debounce counter to 0.
- LFSR:
  - 10-bit Fibonacci, taps 10 and 7.
  - Advances every clk cycle in every phase, so the round seed depends on how long the player waits.
- IDLE: on a start rising edge, clear score and round_num, then go to PROMPT.
- PROMPT:
  - Latch target = LFSR.
  - If target == sw, stay in PROMPT and re-latch next cycle.
  - Otherwise, go to ROUND and load time_left = ROUND_SEC.
- ROUND:
  - led_target = target.
  - debounce counter increments while sw == target and clears on any mismatch.
  - When the counter reaches DEBOUNCE, the round passes:
    - round_num += 1 (saturating).
    - score += award (saturating).
    - Go to BREAK and load time_left = BREAK_SEC.
  - On a tick with time_left == 1, time_left becomes 0 and the FSM goes to OVER.
- BREAK: on a tick with time_left == 1, go to PROMPT.
- OVER:
  - Hold score and round_num.
  - On a start rising edge, go through the same restart path as from IDLE.
- start edges are ignored in PROMPT, ROUND and BREAK.
- Award is computed from round_num before its increment (SCORE_MULT_EN below).

## Timing
- All state and outputs are registered. Outputs change on the clk edge after the causing event.
- Start to first ROUND takes at least 2 cycles: the start edge is registered, then one PROMPT cycle.
- Tick counter:
  - Clears on every ROUND/BREAK entry, so the first decrement comes exactly TICK_DIV cycles after entry.
  - A tick is a 1-cycle strobe when the counter reaches TICK_DIV-1.
- Pass latency: DEBOUNCE cycles of continuous match after the first matching cycle, plus 1 cycle to the BREAK transition.
- Simultaneous pass completion and final tick in the same cycle: the pass wins and the FSM goes to BREAK.
- Reset asserted mid-round: immediate return to reset values. No partial score is kept.
- Saturation: score stays at 1023 and round_num stays at 127. There is no wrap.

## Configuration
- SCORE_MULT_EN defined: award = 2 << (round_num / 5), i.e. 2 per round, doubling after every 5 rounds passed. A shifted value above 1023 saturates the sum.
- SCORE_MULT_EN undefined: flat award of 2 per round. The multiplier logic is not compiled.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE=2, ROUND_SEC=3, BREAK_SEC=2.
1. Reset then start pulse, sw held at 0 → phase goes 0→1→2; time_left=3; led_target nonzero and ≠0; time_left counts 3,2,1 every 4 cycles; at 0 phase=4, game_over=1, score=0.
2. In ROUND, drive sw=led_target for 3 cycles → phase=3, round_num=1, score=2, time_left=2; after 8 cycles phase returns to 1 and then 2.
3. Glitching sw match (1 cycle match, 1 cycle mismatch, repeated) → no pass; timeout to OVER.
4. Match completes on the same cycle as the final tick → phase=3, round_num incremented, game_over stays 0.
5. Pass 6 rounds with SCORE_MULT_EN → score=2·5+4=14. Without the macro → score=12.
6. Assert reset_btn mid-ROUND with score=4 → all outputs 0 and phase=0 asynchronously. A start pulse from OVER clears score to 0 and enters PROMPT.
